// File: rtl/load_store_unit.sv
// Load/store initiator for a word-addressed data memory: RV32I sub-word extraction and RMW sub-word stores.
// Latency from accept: error 1, SW 2, load 3, SB/SH 4 cycles; one request at a time, no response backpressure.
module load_store_unit #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_load,
    input  logic [2:0]       req_funct3,
    input  logic [width-1:0] req_addr,
    input  logic [width-1:0] req_wdata,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [width-1:0] resp_rdata,
    output logic [width-1:0] mem_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic [width-1:0] mem_wdata,
    input  logic [width-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

    state_t             state_q, state_d;
    logic               load_q, load_d;
    logic               err_q, err_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [width-1:0]   addr_q, addr_d;
    logic [width-1:0]   wdata_q, wdata_d;
    logic [width-1:0]   word_q, word_d;

    logic               req_bad;
    logic [7:0]         sel_byte;
    logic [15:0]        sel_half;
    logic [width-1:0]   load_val;
    logic [width-1:0]   store_word;

    always_comb begin
        req_bad = 1'b0;
        if (req_load) begin
            req_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end else begin
            req_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            req_bad = 1'b1;
        end
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            req_bad = 1'b1;
        end
    end

    // Lane data is taken from the word captured in RD_WAIT, not from live mem_rdata.
    always_comb begin
        sel_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
        sel_half = word_q[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q[1:0])
            2'b00:   load_val = {{(width-8){sel_byte[7] & ~funct3_q[2]}}, sel_byte};
            2'b01:   load_val = {{(width-16){sel_half[15] & ~funct3_q[2]}}, sel_half};
            default: load_val = word_q;
        endcase
    end

    always_comb begin
        store_word = word_q;
        case (funct3_q[1:0])
            2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        err_d    = err_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (req_valid) begin
                    load_d   = req_load;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_bad;
                    if (req_bad) begin
                        state_d = RESP;
                    end else if (!req_load && req_funct3[1:0] == 2'b10) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = RD_WAIT;
            RD_WAIT: begin
                word_d  = mem_rdata;
                state_d = load_q ? RESP : WR;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            err_q    <= err_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_read   = (state_q == RD) || (state_q == RD_WAIT);
        mem_write  = (state_q == WR);
        mem_addr   = (mem_read || mem_write) ? {addr_q[width-1:2], 2'b00} : '0;
        mem_wdata  = mem_write ? store_word : '0;
        resp_valid = (state_q == RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && load_q && !err_q) ? load_val : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a combinational-read word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_load = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    int          rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, both_cnt = 0;
    logic [31:0] rd_addr_last = '0, wr_addr_last = '0, wr_dat_last = '0;

    load_store_unit #(.width(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
        else if (pl_we) mem[pl_idx] <= pl_dat;
    end

    always @(negedge clk) begin
        if (mem_read) begin rd_cnt++; rd_addr_last = mem_addr; end
        if (mem_write) begin wr_cnt++; wr_addr_last = mem_addr; wr_dat_last = mem_wdata; end
        if (mem_read && mem_write) both_cnt++;
        if (resp_valid) resp_cnt++;
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = a[11:2]; pl_dat = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Issues one request, scrambles the req_* inputs after accept, waits (bounded) for the response.
    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er);
        @(negedge clk);
        req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_load = ~ld; req_funct3 = 3'b111;
        req_addr = 32'hDEAD_BEE1; req_wdata = 32'hFFFF_FFFF;
        lat = -1; rd = 32'hBAD0_BAD0; er = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++;
        if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got %b want 0000", {resp_valid, resp_err, mem_read, mem_write});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            errors++; $display("FAIL reset_buses got %h/%h/%h want 0", resp_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_byte_loads;
        int lat; logic [31:0] rd; logic er;
        poke(32'd1032, 32'h0000_00B3);
        issue(1'b1, 3'b000, 32'd1032, 32'h0, lat, rd, er);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL lb_latency got %0d want 3", lat); end
        checks++;
        if (rd !== 32'hFFFF_FFB3 || er !== 1'b0) begin errors++; $display("FAIL lb_data got %h err %b want ffffffb3 err 0", rd, er); end
        issue(1'b1, 3'b100, 32'd1032, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0000_00B3 || lat != 3) begin errors++; $display("FAIL lbu_data got %h lat %0d want 000000b3 lat 3", rd, lat); end
    endtask

    task automatic test_word_load;
        int lat, rc0; logic [31:0] rd; logic er;
        poke(32'd1004, 32'h0000_0010);
        rc0 = rd_cnt;
        issue(1'b1, 3'b010, 32'd1004, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0000_0010 || lat != 3) begin errors++; $display("FAIL lw_data got %h lat %0d want 00000010 lat 3", rd, lat); end
        checks++;
        if (rd_cnt - rc0 != 2) begin errors++; $display("FAIL lw_read_cycles got %0d want 2", rd_cnt - rc0); end
        checks++;
        if (rd_addr_last !== 32'd1004) begin errors++; $display("FAIL lw_read_addr got %0d want 1004", rd_addr_last); end
    endtask

    task automatic test_sub_word_stores;
        int lat, wc0; logic [31:0] rd; logic er;
        poke(32'd1012, 32'h0000_0024);
        wc0 = wr_cnt;
        issue(1'b0, 3'b000, 32'd1013, 32'h0000_005A, lat, rd, er);
        checks++;
        if (lat != 4 || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_resp got lat %0d err %b rd %h want 4 0 0", lat, er, rd); end
        checks++;
        if (wr_cnt - wc0 != 1 || wr_addr_last !== 32'd1012 || wr_dat_last !== 32'h0000_5A24) begin
            errors++; $display("FAIL sb_write got n=%0d a=%0d d=%h want 1 1012 00005a24", wr_cnt - wc0, wr_addr_last, wr_dat_last);
        end
        issue(1'b1, 3'b010, 32'd1012, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0000_5A24) begin errors++; $display("FAIL sb_readback got %h want 00005a24", rd); end

        poke(32'd1008, 32'h0000_0038);
        issue(1'b0, 3'b001, 32'd1010, 32'h1234_BEEF, lat, rd, er);
        checks++;
        if (lat != 4 || wr_dat_last !== 32'hBEEF_0038) begin errors++; $display("FAIL sh_write got lat %0d d=%h want 4 beef0038", lat, wr_dat_last); end
        issue(1'b1, 3'b001, 32'd1010, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_data got %h want ffffbeef", rd); end
        issue(1'b1, 3'b101, 32'd1010, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data got %h want 0000beef", rd); end
        issue(1'b1, 3'b010, 32'd1008, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hBEEF_0038) begin errors++; $display("FAIL sh_readback got %h want beef0038", rd); end
    endtask

    task automatic test_word_store;
        int lat, rc0; logic [31:0] rd; logic er;
        rc0 = rd_cnt;
        issue(1'b0, 3'b010, 32'd1016, 32'h1234_5678, lat, rd, er);
        checks++;
        if (lat != 2 || rd_cnt != rc0 || wr_dat_last !== 32'h1234_5678) begin
            errors++; $display("FAIL sw_op got lat %0d reads %0d d=%h want 2 0 12345678", lat, rd_cnt - rc0, wr_dat_last);
        end
        issue(1'b1, 3'b000, 32'd1019, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0000_0012) begin errors++; $display("FAIL sw_lb_top got %h want 00000012", rd); end
    endtask

    task automatic test_errors;
        int lat, rc0, wc0; logic [31:0] rd; logic er;
        rc0 = rd_cnt; wc0 = wr_cnt;
        issue(1'b1, 3'b001, 32'd1001, 32'h0, lat, rd, er);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_lh got lat %0d err %b rd %h want 1 1 0", lat, er, rd); end
        issue(1'b0, 3'b010, 32'd1002, 32'hFFFF_FFFF, lat, rd, er);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_sw got lat %0d err %b rd %h want 1 1 0", lat, er, rd); end
        issue(1'b1, 3'b011, 32'd1004, 32'h0, lat, rd, er);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_f3 got lat %0d err %b rd %h want 1 1 0", lat, er, rd); end
        checks++;
        if (rd_cnt != rc0 || wr_cnt != wc0) begin errors++; $display("FAIL err_strobes got reads %0d writes %0d want 0 0", rd_cnt - rc0, wr_cnt - wc0); end
        @(negedge clk);
        checks++;
        if (resp_err !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL err_idle got err %b ready %b want 0 1", resp_err, req_ready); end
    endtask

    task automatic test_reset_abort;
        int lat, wc0, rs0; logic [31:0] rd; logic er;
        poke(32'd1000, 32'h0000_0008);
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_funct3 = 3'b000; req_addr = 32'd1000; req_wdata = 32'h0000_00AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wc0 = wr_cnt; rs0 = resp_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL abort_now got ready %b read %b addr %h want 1 0 0", req_ready, mem_read, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt != wc0 || resp_cnt != rs0) begin errors++; $display("FAIL abort_quiet got writes %0d resps %0d want 0 0", wr_cnt - wc0, resp_cnt - rs0); end
        issue(1'b1, 3'b010, 32'd1000, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0000_0008 || lat != 3) begin errors++; $display("FAIL abort_readback got %h lat %0d want 00000008 lat 3", rd, lat); end
    endtask

    task automatic test_strobe_exclusive;
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_byte_loads();
        test_word_load();
        test_sub_word_stores();
        test_word_store();
        test_errors();
        test_reset_abort();
        test_strobe_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the word-addressed data memory: accepts one load or store request at a time from the MEM stage and drives `mem_read`/`mem_write`/`mem_addr`/`mem_wdata` toward the memory. It returns loaded data with RV32I byte/halfword extraction and sign or zero extension. Sub-word stores are done as read-modify-write, because the memory only writes whole words. It sits between the core's MEM stage and the data memory.

## Interface
- `width`, 32, data and address width

- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous active-high reset
- `req_valid` in 1, request present
- `req_ready` out 1, unit idle and able to accept
- `req_load` in 1, 1 = load, 0 = store
- `req_funct3` in 3, RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- `req_addr` in `width`, byte address
- `req_wdata` in `width`, store data (right-aligned for SB/SH)
- `resp_valid` out 1, one-cycle completion pulse
- `resp_err` out 1, misaligned or illegal funct3; qualified by `resp_valid`
- `resp_rdata` out `width`, load result; 0 for stores and errors
- `mem_addr` out `width`, word address = `req_addr` with bits [1:0] cleared
- `mem_read` out 1, memory read strobe
- `mem_write` out 1, memory write strobe (memory writes on the clk edge where this is high)
- `mem_wdata` out `width`, full word to write
- `mem_rdata` in `width`, memory read data

## Operation
- FSM states: IDLE, RD, RD_WAIT, WR, RESP. `req_ready` = (state == IDLE).
- IDLE: on `req_valid`, latch load, funct3, addr and wdata, then check the request.
  - Error: halfword with addr[0]=1, word with addr[1:0]≠0, or illegal funct3 (load 011/110/111, store ≥011). Go to RESP with error set; no memory strobe.
  - Load or SB/SH: go to RD.
  - SW: go to WR.
- RD: `mem_read`=1, `mem_addr` valid. Go to RD_WAIT.
- RD_WAIT: `mem_read` and `mem_addr` held, so both combinational and 1-cycle-registered memories are supported. `mem_rdata` is captured at the end of the cycle.
  - Load: go to RESP.
  - SB/SH: go to WR.
- WR: `mem_write`=1 for exactly one cycle with `mem_wdata`, then go to RESP.
  - SW: `mem_wdata` = `req_wdata`.
  - SB: captured word with byte lane addr[1:0] replaced by `req_wdata`[7:0].
  - SH: captured word with halfword lane addr[1] replaced by `req_wdata`[15:0].
- RESP: `resp_valid`=1 for one cycle, then IDLE. There is no response backpressure.
- Load extraction, little-endian: lane selected by addr[1:0] (byte) or addr[1] (half).
  - LB/LH: sign-extend to `width`.
  - LBU/LHU: zero-extend.
  - LW: full word.
- `mem_addr` = 0, `mem_wdata` = 0 and both strobes = 0 whenever not in RD, RD_WAIT or WR.
- `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- Reset (async, takes effect immediately): state IDLE, `req_ready`=1, and all of the following = 0: `resp_valid`, `resp_err`, `resp_rdata`, `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`.
- Latency is counted from the accept edge (`req_valid`&`req_ready`) to the `resp_valid` cycle:
  - Error: 1 cycle.
  - SW: 2 cycles (WR, RESP).
  - Load: 3 cycles (RD, RD_WAIT, RESP).
  - SB/SH: 4 cycles (RD, RD_WAIT, WR, RESP).
- Back-to-back: the next request is accepted on the cycle after RESP. Minimum issue interval is 2 cycles (error) to 5 cycles (SB/SH).
- `req_*` inputs are ignored outside IDLE. Changes to them mid-operation have no effect.
- Reset mid-operation aborts immediately. If reset asserts before the WR edge, no write occurs. No response is generated for the aborted request.
- `resp_rdata` and `resp_err` are only meaningful while `resp_valid`=1. They return to 0 in IDLE.

## Test plan
- Memory preloaded word 1032 = 0x000000B3.
  - LB at 1032 -> `resp_rdata`=0xFFFFFFB3, `resp_err`=0, `resp_valid` 3 cycles after accept.
  - LBU at 1032 -> 0x000000B3.
- Word 1004 = 0x00000010. LW at 1004 -> 0x00000010, with exactly 2 cycles of `mem_read`=1 at `mem_addr`=1004.
- Word 1012 = 0x00000024. SB `req_wdata`=0x5A at addr 1013 -> one `mem_write` pulse, `mem_addr`=1012, `mem_wdata`=0x00005A24. A following LW at 1012 returns 0x00005A24.
- Word 1008 = 0x00000038.
  - SH 0xBEEF at 1010 -> word 1008 becomes 0xBEEF0038.
  - LH at 1010 -> 0xFFFFBEEF.
  - LHU at 1010 -> 0x0000BEEF.
- LH at 1001, SW at 1002, load funct3=011 -> each gives `resp_err`=1 and `resp_rdata`=0 one cycle after accept. `mem_read` and `mem_write` never assert.
- SB to word 1000 (0x00000008) with `rst` pulsed during RD_WAIT -> no `mem_write`, word 1000 unchanged, no `resp_valid`. The unit returns to IDLE with `req_ready`=1 and accepts the next request normally.
